// File: rtl/alu_arbiter_pkg.sv
// Shared types for the two-port ALU arbiter:
// FSM states, ALU function codes and opcode helpers.
package alu_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [3:0] FUNC_AND = 4'd0;
   localparam logic [3:0] FUNC_OR  = 4'd1;
   localparam logic [3:0] FUNC_ADD = 4'd2;
   localparam logic [3:0] FUNC_LLS = 4'd3;
   localparam logic [3:0] FUNC_LRS = 4'd4;
   localparam logic [3:0] FUNC_ARS = 4'd5;
   localparam logic [3:0] FUNC_SUB = 4'd6;
   localparam logic [3:0] FUNC_SLT = 4'd7;
   localparam logic [3:0] FUNC_XOR = 4'd8;
   localparam logic [3:0] FUNC_NOR = 4'd12;

   // Only add/sub produce a meaningful overflow flag.
   function automatic logic has_ovf(input logic [3:0] f);
      return (f == FUNC_ADD) || (f == FUNC_SUB);
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue logic and the
// ALU arbiter; master is the issue side, slave the arbiter.
interface alu_arbiter_if #(
   parameter int data_width = 16
);
   logic                  req0_valid;
   logic                  req0_ready;
   logic [data_width-1:0] req0_A;
   logic [data_width-1:0] req0_B;
   logic [3:0]            req0_FuncCode;
   logic                  req1_valid;
   logic                  req1_ready;
   logic [data_width-1:0] req1_A;
   logic [data_width-1:0] req1_B;
   logic [3:0]            req1_FuncCode;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic                  rsp_id;
   logic [data_width-1:0] rsp_C;
   logic                  rsp_OverflowFlag;
   logic                  busy;

   modport master (
      output req0_valid, req0_A, req0_B, req0_FuncCode,
      output req1_valid, req1_A, req1_B, req1_FuncCode,
      output rsp_ready,
      input  req0_ready, req1_ready,
      input  rsp_valid, rsp_id, rsp_C, rsp_OverflowFlag,
      input  busy
   );

   modport slave (
      input  req0_valid, req0_A, req0_B, req0_FuncCode,
      input  req1_valid, req1_A, req1_B, req1_FuncCode,
      input  rsp_ready,
      output req0_ready, req1_ready,
      output rsp_valid, rsp_id, rsp_C, rsp_OverflowFlag,
      output busy
   );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Shared combinational ALU. The overflow output is not
// cleared for non-arithmetic ops; callers must mask it.
module ALU
   import alu_arbiter_pkg::*;
#(
   parameter int data_width = 16
) (
   input  logic [data_width-1:0] A,
   input  logic [data_width-1:0] B,
   input  logic [3:0]            FuncCode,
   output logic [data_width-1:0] C,
   output logic                  OverflowFlag
);
   localparam int SW  = $clog2(data_width);
   localparam int MSB = data_width - 1;

   logic [data_width-1:0] sum;
   logic [data_width-1:0] dif;
   logic [SW-1:0]         sh;
   logic                  ov_add;
   logic                  ov_sub;

   assign sum = A + B;
   assign dif = A - B;
   assign sh  = B[SW-1:0];

   assign ov_add = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
   assign ov_sub = (A[MSB] != B[MSB]) && (dif[MSB] != A[MSB]);

   assign OverflowFlag = (FuncCode == FUNC_SUB) ? ov_sub : ov_add;

   always_comb begin
      C = '0;
      unique case (FuncCode)
         FUNC_AND: C = A & B;
         FUNC_OR:  C = A | B;
         FUNC_ADD: C = sum;
         FUNC_SUB: C = dif;
         FUNC_XOR: C = A ^ B;
         FUNC_NOR: C = ~(A | B);
         FUNC_LLS: C = A << sh;
         FUNC_LRS: C = A >> sh;
         FUNC_ARS: C = $unsigned($signed(A) >>> sh);
         FUNC_SLT: begin
            C = {{(data_width-1){1'b0}},
                 ($signed(A) < $signed(B))};
         end
         default:  C = '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick; prio_i names the tie winner.
// Purely combinational.
module rr_pick2 (
   input  logic [1:0] valid_i,
   input  logic       prio_i,
   output logic [1:0] gnt_o,
   output logic       id_o
);
   assign gnt_o[0] = valid_i[0] & (~valid_i[1] | ~prio_i);
   assign gnt_o[1] = valid_i[1] & (~valid_i[0] |  prio_i);
   assign id_o     = gnt_o[1];
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin front end for the shared ALU: accept, execute
// from a private operand register, hold result until taken.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int data_width = 16
) (
   input  logic         clk,
   input  logic         reset,
   alu_arbiter_if.slave bus
);
   state_e                state_q, state_d;
   logic                  prio_q, prio_d;
   logic [data_width-1:0] a_q, a_d;
   logic [data_width-1:0] b_q, b_d;
   logic [3:0]            f_q, f_d;
   logic                  id_q, id_d;
   logic [data_width-1:0] c_q, c_d;
   logic                  ov_q, ov_d;
   logic                  rid_q, rid_d;

   logic [1:0]            gnt;
   logic                  gid;
   logic [1:0]            rdy;
   logic [data_width-1:0] alu_c;
   logic                  alu_ov;

   rr_pick2 u_pick (
      .valid_i ({bus.req1_valid, bus.req0_valid}),
      .prio_i  (prio_q),
      .gnt_o   (gnt),
      .id_o    (gid)
   );

   ALU #(
      .data_width (data_width)
   ) u_alu (
      .A            (a_q),
      .B            (b_q),
      .FuncCode     (f_q),
      .C            (alu_c),
      .OverflowFlag (alu_ov)
   );

   always_comb begin
      state_d = state_q;
      prio_d  = prio_q;
      a_d     = a_q;
      b_d     = b_q;
      f_d     = f_q;
      id_d    = id_q;
      c_d     = c_q;
      ov_d    = ov_q;
      rid_d   = rid_q;
      rdy     = 2'b00;
      unique case (state_q)
         IDLE: begin
            if (|gnt) begin
               // Readies stay low while reset is held.
               rdy     = gnt & {2{~reset}};
               a_d     = gid ? bus.req1_A : bus.req0_A;
               b_d     = gid ? bus.req1_B : bus.req0_B;
               f_d     = gid ? bus.req1_FuncCode
                             : bus.req0_FuncCode;
               id_d    = gid;
               state_d = EXEC;
            end
         end
         EXEC: begin
            c_d     = alu_c;
            ov_d    = has_ovf(f_q) & alu_ov;
            rid_d   = id_q;
            state_d = RESP;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               prio_d  = ~rid_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         prio_q  <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         f_q     <= '0;
         id_q    <= 1'b0;
         c_q     <= '0;
         ov_q    <= 1'b0;
         rid_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prio_q  <= prio_d;
         a_q     <= a_d;
         b_q     <= b_d;
         f_q     <= f_d;
         id_q    <= id_d;
         c_q     <= c_d;
         ov_q    <= ov_d;
         rid_q   <= rid_d;
      end
   end

   assign bus.req0_ready       = rdy[0];
   assign bus.req1_ready       = rdy[1];
   assign bus.rsp_valid        = (state_q == RESP);
   assign bus.rsp_id           = rid_q;
   assign bus.rsp_C            = c_q;
   assign bus.rsp_OverflowFlag = ov_q;
   assign bus.busy             = (state_q != IDLE);

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester front end for the shared combinational `ALU` (16-bit, 4-bit FuncCode). It arbitrates round-robin between two request ports and latches the winning operands into a private operand register. It drives the `ALU` from that register and holds the registered result and overflow flag on a valid/ready response port until it is consumed. It sits between the instruction-issue logic and the `ALU`; nothing else drives the `ALU` inputs.

## Interface
- `data_width`, 16, operand/result width passed to the `ALU`
- `clk` in 1, single clock; all state updates on rising edge
- `reset` in 1, synchronous, active-high
- `req0_valid` in 1, requester 0 has an operation
- `req0_ready` out 1, requester 0 handshake accepted this cycle
- `req0_A`, `req0_B` in data_width, operands from requester 0
- `req0_FuncCode` in 4, ALU opcode from requester 0 (header encodings)
- `req1_valid`, `req1_ready`, `req1_A`, `req1_B`, `req1_FuncCode`: same signals for requester 1
- `rsp_valid` out 1, result available
- `rsp_ready` in 1, consumer takes result
- `rsp_id` out 1, index of the requester that owns the result
- `rsp_C` out data_width, registered ALU result
- `rsp_OverflowFlag` out 1, registered overflow; 0 for any op other than FUNC_ADD/FUNC_SUB
- `busy` out 1, high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - If no valid is high, stay in IDLE.
  - Otherwise grant one requester. If only one valid is high, grant it. If both are high, grant the one equal to the priority pointer `prio`.
  - `reqN_ready` = 1 for the granted N only. It is combinational from state, valids and `prio`. Both readies are 0 outside IDLE.
  - On grant, latch A/B/FuncCode and the grant id into the operand register, then go to EXEC.
- **EXEC**
  - The `ALU` inputs are driven from the operand register.
  - At the clock edge, capture `ALU` C into `rsp_C` and go to RESP.
  - Overflow capture: if FuncCode is FUNC_ADD or FUNC_SUB, capture the `ALU` OverflowFlag into `rsp_OverflowFlag`; otherwise capture 0. The `ALU`'s own flag is not cleared on other ops, so this masking is mandatory.
- **RESP**
  - `rsp_valid` = 1. `rsp_C`, `rsp_OverflowFlag` and `rsp_id` are stable until the handshake.
  - On `rsp_valid & rsp_ready`: go to IDLE and set `prio` = ~`rsp_id`, so the other requester wins the next tie.
  - Without `rsp_ready`, hold indefinitely.
- Requester valid/data may change freely when ready is low. The block samples them only in the handshake cycle.
- Arithmetic and width rules belong to the `ALU`. The block adds no extension or truncation.

## Timing
- Reset values:
  - state = IDLE, `prio` = 0, operand register = 0.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_C` = 0, `rsp_OverflowFlag` = 0, `busy` = 0.
  - Both readies = 0 during reset.
- Latency: request handshake in cycle N → `rsp_valid` high in cycle N+2.
- Minimum spacing between accepted requests is 3 cycles: handshake at N, earliest `rsp_ready` at N+2, next accept at N+3.
- No request is accepted in the same cycle as a response handshake.
- Simultaneous valids in IDLE: exactly one ready is asserted. The loser keeps valid high and is granted on the next IDLE cycle if no new tie rule overrides it. The pointer guarantees alternation under continuous contention.
- Reset mid-EXEC or mid-RESP aborts the operation. The result is dropped, `rsp_valid` = 0 next cycle, and no ready is asserted until the cycle after reset deasserts.
- `rsp_ready` high while `rsp_valid` = 0 is ignored.

## Structure
- FuncCode encodings (FUNC_ADD, FUNC_SUB, …) come from the existing shared header `alu_func.v`. The FSM state encodings (IDLE=2'd0, EXEC=2'd1, RESP=2'd2) go in a new shared header `alu_arbiter_defs.v`.
- The block instantiates the existing `ALU` module once, with `data_width` passed through.
- Add one small sub-module, `rr_pick2`, that is purely combinational. Inputs are two valids and `prio`; outputs are a grant one-hot and a grant id. The FSM, operand register and response register stay in `alu_arbiter`.

## Test plan
1. **Reset.** Assert reset for 2 cycles with both valids high. Required: both readies = 0, `rsp_valid` = 0, `busy` = 0. After release, req0 is granted first (`prio` = 0).
2. **Single add.** req0: A=16'h0003, B=16'h0004, FUNC_ADD, accepted at cycle N. Required: `rsp_valid` at N+2 with `rsp_C`=16'h0007, `rsp_OverflowFlag`=0, `rsp_id`=0.
3. **Overflow and masking.**
   - req1: A=16'h7FFF, B=16'h0001, FUNC_ADD. Required: `rsp_C`=16'h8000, `rsp_OverflowFlag`=1.
   - Follow with a FUNC_LLS op. Required: `rsp_OverflowFlag`=0.
4. **Contention.** Hold both valids for 4 transactions. Required: grants alternate 0,1,0,1 and `rsp_id` matches each grant.
5. **Backpressure.** Hold `rsp_ready`=0 for 5 cycles in RESP. Required: `rsp_C` and `rsp_id` are stable, both readies = 0, and `busy` = 1. Handshake on cycle 6 → IDLE next cycle.
6. **Reset mid-RESP.** Assert reset while `rsp_valid`=1. Required: `rsp_valid`=0 the next cycle, state IDLE, `prio`=0, and no response is ever delivered for the aborted op.
